// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller for a five-stage pipeline: load-use stall,
// EX-stage operand forwarding selects and one-cycle squash behind a taken redirect.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rn,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_redirect,
  output logic             stall,
  output logic             wpcir,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             squash,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0]       ex_rn_q, mem_rn_q;
  logic             ex_wreg_q, ex_m2reg_q, mem_wreg_q, mem_m2reg_q;
  logic             squash_q, squash_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, squash_cnt_q, squash_cnt_d;
  logic             v, ex_load_nz, issue;

  // Select for one source operand; EX (youngest) is checked before MEM.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src, input logic use_src, input logic valid,
    input logic [4:0] e_rn, input logic e_wreg, input logic e_m2reg,
    input logic [4:0] m_rn, input logic m_wreg, input logic m_m2reg
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (valid && use_src) begin
      if (e_wreg && !e_m2reg && e_rn == src && e_rn != 5'd0)
        sel = 2'd1;
      else if (m_wreg && !m_m2reg && m_rn == src && m_rn != 5'd0)
        sel = 2'd2;
      else if (m_wreg && m_m2reg && m_rn == src && m_rn != 5'd0)
        sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    v          = ~squash_q;
    ex_load_nz = ex_wreg_q & ex_m2reg_q & (ex_rn_q != 5'd0);
    stall      = v & ex_load_nz &
                 ((id_use_rs & (ex_rn_q == id_rs)) | (id_use_rt & (ex_rn_q == id_rt)));
    wpcir      = ~stall;
    issue      = v & ~stall;
    fwda       = fwd_sel(id_rs, id_use_rs, v, ex_rn_q, ex_wreg_q, ex_m2reg_q,
                         mem_rn_q, mem_wreg_q, mem_m2reg_q);
    fwdb       = fwd_sel(id_rt, id_use_rt, v, ex_rn_q, ex_wreg_q, ex_m2reg_q,
                         mem_rn_q, mem_wreg_q, mem_m2reg_q);
    // A redirect seen during a stall is dropped; ID is re-presented next cycle.
    squash_d   = issue & id_redirect;
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (squash_q && squash_cnt_q != CNT_MAX)
      squash_cnt_d = squash_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ex_rn_q      <= 5'd0;
      ex_wreg_q    <= 1'b0;
      ex_m2reg_q   <= 1'b0;
      mem_rn_q     <= 5'd0;
      mem_wreg_q   <= 1'b0;
      mem_m2reg_q  <= 1'b0;
      squash_q     <= 1'b0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      mem_rn_q     <= ex_rn_q;
      mem_wreg_q   <= ex_wreg_q;
      mem_m2reg_q  <= ex_m2reg_q;
      ex_rn_q      <= id_rn;
      ex_wreg_q    <= id_wreg & issue;
      ex_m2reg_q   <= id_m2reg & issue;
      squash_q     <= squash_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign squash     = squash_q;
  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus a random
// instruction stream, scored against an instruction-level model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rn = '0;
  logic        id_use_rs = 0, id_use_rt = 0, id_wreg = 0, id_m2reg = 0, id_redirect = 0;
  logic        stall, wpcir, squash;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt, squash_cnt;
  logic        s_stall, s_wpcir, s_squash;
  logic [1:0]  s_fwda, s_fwdb;
  logic [1:0]  s_stall_cnt, s_squash_cnt;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .clr(clr), .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_redirect(id_redirect), .stall(stall), .wpcir(wpcir),
    .fwda(fwda), .fwdb(fwdb), .squash(squash), .stall_cnt(stall_cnt),
    .squash_cnt(squash_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .clr(clr), .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_redirect(id_redirect), .stall(s_stall), .wpcir(s_wpcir),
    .fwda(s_fwda), .fwdb(s_fwdb), .squash(s_squash), .stall_cnt(s_stall_cnt),
    .squash_cnt(s_squash_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  // Model: entry 0 is the instruction in EX, entry 1 the one in MEM.
  logic [4:0] s_rn[2];
  logic       s_wr[2], s_m2[2];
  logic       m_sq;
  int         m_scnt, m_qcnt;
  logic       m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s_rn[i] = '0; s_wr[i] = 1'b0; s_m2[i] = 1'b0;
    end
    m_sq = 1'b0; m_scnt = 0; m_qcnt = 0;
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic u);
    if (!u || m_sq || r == 5'd0) return 2'd0;
    if (s_wr[0] && !s_m2[0] && s_rn[0] == r) return 2'd1;
    if (s_wr[1] && s_rn[1] == r) return s_m2[1] ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  // One ID cycle: drive the instruction, predict, compare at negedge, advance model.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                      input logic urs, input logic urt, input logic wr, input logic m2,
                      input logic rd);
    logic [6:0] ev, got;
    logic       go;
    @(posedge clk); #1;
    id_rs = rs; id_rt = rt; id_rn = rn; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = m2; id_redirect = rd;
    m_stall = !m_sq && s_wr[0] && s_m2[0] && s_rn[0] != 5'd0 &&
              ((urs && s_rn[0] == rs) || (urt && s_rn[0] == rt));
    exp_q.push_back({m_stall, ~m_stall, m_fwd(rs, urs), m_fwd(rt, urt), m_sq});
    @(negedge clk);
    got = {stall, wpcir, fwda, fwdb, squash};
    ev  = exp_q.pop_front();
    check("stall_wpcir_fwda_fwdb_squash", {25'd0, got}, {25'd0, ev});
    check("stall_cnt", {16'd0, stall_cnt}, m_scnt);
    check("squash_cnt", {16'd0, squash_cnt}, m_qcnt);
    go = !m_sq && !m_stall;
    if (m_stall && m_scnt < 32'hFFFF) m_scnt++;
    if (m_sq && m_qcnt < 32'hFFFF) m_qcnt++;
    s_rn[1] = s_rn[0]; s_wr[1] = s_wr[0]; s_m2[1] = s_m2[0];
    s_rn[0] = rn; s_wr[0] = wr && go; s_m2[0] = m2 && go;
    m_sq = go && rd;
  endtask

  task automatic mid_reset();
    #2 clr = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_wpcir", {31'd0, wpcir}, 1);
    check("rst_squash", {31'd0, squash}, 0);
    check("rst_fwd", {28'd0, fwda, fwdb}, 0);
    check("rst_cnts", {stall_cnt, squash_cnt}, 0);
    @(posedge clk); #1;
    check("rst_hold_stall", {31'd0, stall}, 0);
    check("rst_hold_cnts", {stall_cnt, squash_cnt}, 0);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] rs, rt, rn;
    logic urs, urt, wr, m2, rd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_stall", {31'd0, stall}, 0);
    check("init_wpcir", {31'd0, wpcir}, 1);
    check("init_cnts", {stall_cnt, squash_cnt}, 0);
    @(negedge clk) clr = 1'b0;

    // Build up counters, then reset while a load sits in EX mid-stall.
    step(5'd0, 5'd0, 5'd7, 0, 0, 1, 1, 0);
    step(5'd7, 5'd2, 5'd8, 1, 1, 1, 0, 0);
    step(5'd7, 5'd2, 5'd8, 1, 1, 1, 0, 0);
    step(5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 1);
    step(5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 0);
    step(5'd0, 5'd0, 5'd7, 0, 0, 1, 1, 0);
    step(5'd7, 5'd2, 5'd8, 1, 1, 1, 0, 0);
    check("pre_rst_stall", {31'd0, stall}, 1);
    mid_reset();
    step(5'd7, 5'd2, 5'd8, 1, 1, 1, 0, 0);
    check("post_rst_stall", {31'd0, stall}, 0);
    check("post_rst_squash", {31'd0, squash}, 0);

    // ALU chain: EX forward, then MEM forward with one instruction between.
    step(5'd3, 5'd4, 5'd5, 1, 1, 1, 0, 0);
    step(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0);
    check("alu_ex_fwd", {28'd0, fwda, fwdb}, 4'b0101);
    check("alu_ex_stall", {31'd0, stall}, 0);
    step(5'd3, 5'd4, 5'd5, 1, 1, 1, 0, 0);
    step(5'd1, 5'd2, 5'd10, 1, 1, 1, 0, 0);
    step(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0);
    check("alu_mem_fwd", {28'd0, fwda, fwdb}, 4'b1010);

    // Load-use: one stall, then load-data forward.
    step(5'd1, 5'd0, 5'd7, 1, 0, 1, 1, 0);
    step(5'd7, 5'd2, 5'd8, 1, 1, 1, 0, 0);
    check("lu_stall", {31'd0, stall}, 1);
    check("lu_wpcir", {31'd0, wpcir}, 0);
    step(5'd7, 5'd2, 5'd8, 1, 1, 1, 0, 0);
    check("lu_fwd3", {30'd0, fwda}, 2'd3);
    check("lu_nostall", {31'd0, stall}, 0);
    check("lu_cnt", {16'd0, stall_cnt}, 1);

    // Priority: EX beats MEM; r0 never forwards or stalls.
    step(5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 0);
    step(5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 0);
    step(5'd9, 5'd0, 5'd1, 1, 0, 1, 0, 0);
    check("prio_ex", {30'd0, fwda}, 2'd1);
    step(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0);
    step(5'd0, 5'd0, 5'd2, 1, 1, 1, 0, 0);
    check("r0_fwd", {28'd0, fwda, fwdb}, 0);
    check("r0_stall", {31'd0, stall}, 0);

    // Branch: bubble behind it must not forward later.
    step(5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1);
    step(5'd0, 5'd0, 5'd11, 0, 0, 1, 1, 0);
    check("br_squash", {31'd0, squash}, 1);
    step(5'd11, 5'd11, 5'd12, 1, 1, 1, 0, 0);
    check("br_bubble_fwd", {28'd0, fwda, fwdb, 1'b0, stall} >> 1, 0);
    check("br_bubble_stall", {31'd0, stall}, 0);
    check("br_cnt", {16'd0, squash_cnt}, 1);
    step(5'd11, 5'd11, 5'd13, 1, 1, 1, 0, 0);
    check("br_bubble_mem", {28'd0, fwda, fwdb}, 0);

    // Redirect during a load-use stall is deferred until the stall clears.
    step(5'd0, 5'd0, 5'd14, 0, 0, 1, 1, 0);
    step(5'd14, 5'd1, 5'd0, 1, 1, 0, 0, 1);
    check("rd_stall", {31'd0, stall}, 1);
    step(5'd14, 5'd1, 5'd0, 1, 1, 0, 0, 1);
    check("rd_no_squash_yet", {31'd0, squash}, 0);
    step(5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 0);
    check("rd_squash_late", {31'd0, squash}, 1);

    // Extra load-use pairs to drive the narrow counters into saturation.
    for (int k = 0; k < 5; k++) begin
      step(5'd0, 5'd0, 5'd15, 0, 0, 1, 1, 0);
      step(5'd1, 5'd15, 5'd16, 0, 1, 1, 0, 0);
      step(5'd1, 5'd15, 5'd16, 0, 1, 1, 0, 0);
    end
    check("sat_min_stalls", {31'd0, (m_scnt >= 5)}, 1);
    check("sat_stall_cnt", {30'd0, s_stall_cnt}, 3);

    // Random stream; a stalled instruction is re-presented, as the datapath would.
    rs = 0; rt = 0; rn = 0; urs = 0; urt = 0; wr = 0; m2 = 0; rd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!m_stall || n == 0) begin
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
        rn = 5'($urandom_range(0, 7));
        urs = 1'($urandom_range(0, 1)); urt = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 3) != 0); m2 = ($urandom_range(0, 2) == 0);
        rd = ($urandom_range(0, 5) == 0);
      end
      step(rs, rt, rn, urs, urt, wr, m2, rd);
    end
    check("sat_stall_final", {30'd0, s_stall_cnt}, (m_scnt > 3) ? 3 : m_scnt);
    check("sat_squash_final", {30'd0, s_squash_cnt}, (m_qcnt > 3) ? 3 : m_qcnt);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
